// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: pipelined LEGv8 execute stage feeding the EX/MEM register.
// Operand-B select, ALU/shift decode, branch resolution and a valid/ready
// register slice. Define EX_STAGE_MUL_EN to add an iterative shift-add MUL
// (MUL_BUSY state); otherwise the MUL opcode decodes as illegal.
module ex_stage_pipe #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned REG_AW  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   pc,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [DATA_W-1:0]   imm,
  input  logic [DATA_W-1:0]   rs1_data,
  input  logic [DATA_W-1:0]   rs2_data,
  input  logic [1:0]          alu_src,
  input  logic [1:0]          alu_op,
  input  logic                b,
  input  logic                bz,
  input  logic                bnz,
  input  logic                mem_write,
  input  logic                mem_read,
  input  logic                mem_to_reg,
  input  logic                reg_write,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [DATA_W-1:0]   out_store_data,
  output logic [REG_AW-1:0]   out_rd,
  output logic [DATA_W-1:0]   out_branch_addr,
  output logic                out_pc_src,
  output logic                out_mem_write,
  output logic                out_mem_read,
  output logic                out_mem_to_reg,
  output logic                out_reg_write,
  output logic                out_illegal
);

  localparam int unsigned OPC_W = 11;
  localparam logic [OPC_W-1:0] OPC_ADD = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR = 11'b10101010000;
  localparam logic [OPC_W-1:0] OPC_LSL = 11'b11010011011;
  localparam logic [OPC_W-1:0] OPC_LSR = 11'b11010011010;
  localparam logic [OPC_W-1:0] OPC_MUL = 11'b10011011000;

  logic [OPC_W-1:0]  opcode_c;
  logic [5:0]        shamt_c;
  logic [DATA_W-1:0] opb_c;
  logic [DATA_W-1:0] alu_res_c;
  logic              illegal_c;
  logic              is_mul_c;
  logic              pc_src_c;
  logic              idle_c;
  logic              accept_c;
  logic              unused_instr_c;

  assign opcode_c       = instr[INSTR_W-1 -: OPC_W];
  assign shamt_c        = instr[15:10];
  assign unused_instr_c = ^instr;

  // Operand B select; encoding 11 is flagged illegal in the ALU block
  always_comb begin
    opb_c = rs2_data;
    case (alu_src)
      2'b01:   opb_c = imm;
      2'b10:   opb_c = DATA_W'(instr[21:10]);
      default: opb_c = rs2_data;
    endcase
  end

  // ALU op decode and result; any illegal source zeroes the result
  always_comb begin
    alu_res_c = '0;
    illegal_c = (alu_src == 2'b11);
    is_mul_c  = 1'b0;
    case (alu_op)
      2'b00: alu_res_c = rs1_data + opb_c;
      2'b01: alu_res_c = opb_c;
      2'b10: begin
        case (opcode_c)
          OPC_ADD: alu_res_c = rs1_data + opb_c;
          OPC_SUB: alu_res_c = rs1_data - opb_c;
          OPC_AND: alu_res_c = rs1_data & opb_c;
          OPC_ORR: alu_res_c = rs1_data | opb_c;
          OPC_LSL: alu_res_c = rs1_data << shamt_c;
          OPC_LSR: alu_res_c = rs1_data >> shamt_c;
`ifdef EX_STAGE_MUL_EN
          OPC_MUL: is_mul_c = 1'b1;
`else
          OPC_MUL: illegal_c = 1'b1;
`endif
          default: illegal_c = 1'b1;
        endcase
      end
      default: illegal_c = 1'b1;
    endcase
    if (illegal_c) begin
      alu_res_c = '0;
      is_mul_c  = 1'b0;
    end
  end

  assign pc_src_c = b | (bz & (alu_res_c == '0)) | (bnz & (alu_res_c != '0));

  assign in_ready = ~reset & ~flush & idle_c & (~out_valid | out_ready);
  assign accept_c = in_valid & in_ready;

`ifdef EX_STAGE_MUL_EN
  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_e;

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_step_c;
  logic              mb_q;
  logic              mbz_q;
  logic              mbnz_q;
  logic              mul_done_c;
  logic              mul_pc_src_c;

  assign idle_c       = (state_q == IDLE);
  assign mul_done_c   = (state_q == MUL_BUSY) && (cnt_q == CNT_W'(DATA_W - 1));
  assign acc_step_c   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_pc_src_c = mb_q | (mbz_q & (acc_step_c == '0)) | (mbnz_q & (acc_step_c != '0));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: MUL occupies the stage for DATA_W iterations
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept_c && is_mul_c) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_done_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Shift-add multiplier, one multiplier bit per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mb_q     <= 1'b0;
      mbz_q    <= 1'b0;
      mbnz_q   <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept_c && is_mul_c) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= rs1_data;
      mplier_q <= opb_c;
      mb_q     <= b;
      mbz_q    <= bz;
      mbnz_q   <= bnz;
    end else if (state_q == MUL_BUSY) begin
      cnt_q    <= cnt_q + CNT_W'(1);
      acc_q    <= acc_step_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end
`else
  assign idle_c = 1'b1;
`endif

  // EX/MEM register with valid/ready hold; flush only drops valid
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_store_data  <= '0;
      out_rd          <= '0;
      out_branch_addr <= '0;
      out_pc_src      <= 1'b0;
      out_mem_write   <= 1'b0;
      out_mem_read    <= 1'b0;
      out_mem_to_reg  <= 1'b0;
      out_reg_write   <= 1'b0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_c) begin
      out_store_data  <= rs2_data;
      out_rd          <= instr[REG_AW-1:0];
      out_branch_addr <= pc + (imm << 2);
      out_mem_write   <= mem_write & ~illegal_c;
      out_mem_read    <= mem_read;
      out_mem_to_reg  <= mem_to_reg;
      out_reg_write   <= reg_write & ~illegal_c;
      out_illegal     <= illegal_c;
      if (is_mul_c) begin
        out_valid <= 1'b0;
      end else begin
        out_result <= alu_res_c;
        out_pc_src <= pc_src_c;
        out_valid  <= 1'b1;
      end
`ifdef EX_STAGE_MUL_EN
    end else if (mul_done_c) begin
      out_result <= acc_step_c;
      out_pc_src <= mul_pc_src_c;
      out_valid  <= 1'b1;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed and randomized checks of ex_stage_pipe against
// a one-deep behavioural model of the EX/MEM slot.
module tb_ex_stage_pipe;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [1:0]  alu_src;
    logic [1:0]  alu_op;
    logic        b, bz, bnz, mw, mr, m2r, rw;
  } bundle_t;

  typedef struct packed {
    logic [63:0] result;
    logic [63:0] baddr;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        pc_src, illegal, rw, mw, mr, m2r;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] pc, imm, rs1_data, rs2_data;
  logic [31:0] instr;
  logic [1:0]  alu_src, alu_op;
  logic        b, bz, bnz, mem_write, mem_read, mem_to_reg, reg_write;
  logic [63:0] out_result, out_store_data, out_branch_addr;
  logic [4:0]  out_rd;
  logic        out_pc_src, out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write, out_illegal;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_stage_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .instr(instr), .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_src(alu_src), .alu_op(alu_op), .b(b), .bz(bz), .bnz(bnz),
    .mem_write(mem_write), .mem_read(mem_read), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_branch_addr(out_branch_addr),
    .out_pc_src(out_pc_src), .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bundle_t nop();
    bundle_t x;
    x = '0;
    return x;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [10:0] opc, input logic [5:0] sh,
                                           input logic [4:0] rd);
    logic [31:0] i;
    i = {opc, 21'd0};
    i[15:10] = sh;
    i[4:0] = rd;
    return i;
  endfunction

  task automatic apply(input bundle_t x);
    pc = x.pc; instr = x.instr; imm = x.imm; rs1_data = x.rs1; rs2_data = x.rs2;
    alu_src = x.alu_src; alu_op = x.alu_op; b = x.b; bz = x.bz; bnz = x.bnz;
    mem_write = x.mw; mem_read = x.mr; mem_to_reg = x.m2r; reg_write = x.rw;
  endtask

  // Reference: what the EX/MEM register should hold for one bundle
  function automatic exp_t model(input bundle_t x);
    exp_t e;
    logic [63:0] opb, r;
    logic ill;
    ill = (x.alu_src == 2'd3);
    opb = (x.alu_src == 2'd1) ? x.imm : (x.alu_src == 2'd2) ? 64'(x.instr[21:10]) : x.rs2;
    r = 64'd0;
    if (x.alu_op == 2'd0) r = x.rs1 + opb;
    else if (x.alu_op == 2'd1) r = opb;
    else if (x.alu_op == 2'd3) ill = 1'b1;
    else begin
      case (x.instr[31:21])
        OP_ADD: r = x.rs1 + opb;
        OP_SUB: r = x.rs1 - opb;
        OP_AND: r = x.rs1 & opb;
        OP_ORR: r = x.rs1 | opb;
        OP_LSL: r = x.rs1 * (64'd1 << x.instr[15:10]);
        OP_LSR: r = x.rs1 / (64'd1 << x.instr[15:10]);
`ifdef EX_STAGE_MUL_EN
        OP_MUL: r = x.rs1 * opb;
`endif
        default: ill = 1'b1;
      endcase
    end
    if (ill) r = 64'd0;
    e.result  = r;
    e.pc_src  = x.b | (x.bz && r == 0) | (x.bnz && r != 0);
    e.baddr   = x.pc + x.imm * 64'd4;
    e.sd      = x.rs2;
    e.rd      = x.instr[4:0];
    e.illegal = ill;
    e.rw      = x.rw && !ill;
    e.mw      = x.mw && !ill;
    e.mr      = x.mr;
    e.m2r     = x.m2r;
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check1({tag, "_valid"}, out_valid, 1'b1);
    check64({tag, "_result"}, out_result, e.result);
    check64({tag, "_baddr"}, out_branch_addr, e.baddr);
    check64({tag, "_sdata"}, out_store_data, e.sd);
    check64({tag, "_ctrl"},
            64'({out_rd, out_pc_src, out_illegal, out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg}),
            64'({e.rd, e.pc_src, e.illegal, e.rw, e.mw, e.mr, e.m2r}));
  endtask

  // Present a bundle until accepted, then count cycles until out_valid
  task automatic run_op(input bundle_t x, output int lat);
    apply(x);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  function automatic bundle_t rnd_bundle();
    bundle_t x;
    logic [10:0] opc;
    case ($urandom_range(0, 6))
      0: opc = OP_ADD;
      1: opc = OP_SUB;
      2: opc = OP_AND;
      3: opc = OP_ORR;
      4: opc = OP_LSL;
      5: opc = OP_LSR;
      default: opc = 11'($urandom);
    endcase
    if (opc == OP_MUL) opc = OP_ADD;
    x.pc      = {$urandom, $urandom};
    x.instr   = {opc, 21'($urandom)};
    x.imm     = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
    x.rs1     = {$urandom, $urandom};
    x.rs2     = ($urandom_range(0, 3) == 0) ? x.rs1 :
                ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom, $urandom};
    x.alu_src = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    x.alu_op  = ($urandom_range(0, 7) == 0) ? 2'd3 :
                ($urandom_range(0, 1) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
    x.b       = ($urandom_range(0, 5) == 0);
    x.bz      = ($urandom_range(0, 2) == 0);
    x.bnz     = ($urandom_range(0, 2) == 0);
    x.mw      = 1'($urandom);
    x.mr      = 1'($urandom);
    x.m2r     = 1'($urandom);
    x.rw      = 1'($urandom);
    return x;
  endfunction

  initial begin
    bundle_t x, xa, xb;
    exp_t    e, ea, eb, mdl;
    int      lat;
    logic    mdl_valid, exp_rdy, seen;

    // Reset held for three cycles
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    apply(nop());
    repeat (3) tick();
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check64("rst_result", out_result, 64'd0);
    check64("rst_baddr", out_branch_addr, 64'd0);
    check64("rst_sdata", out_store_data, 64'd0);
    check64("rst_ctrl", 64'({out_rd, out_pc_src, out_illegal, out_reg_write, out_mem_write,
                              out_mem_read, out_mem_to_reg}), 64'd0);
    reset = 1'b0;
    #1;
    check1("post_rst_in_ready", in_ready, 1'b1);

    // ADD 5 + 7
    x = nop(); x.instr = mk_instr(OP_ADD, 6'd0, 5'd3); x.alu_op = 2'd2;
    x.rs1 = 64'd5; x.rs2 = 64'd7; x.rw = 1'b1;
    run_op(x, lat);
    check64("add_latency", 64'(lat), 64'd1);
    check64("add_result", out_result, 64'd12);
    check1("add_illegal", out_illegal, 1'b0);
    check_out("add", model(x));
    tick();
    check1("add_popped", out_valid, 1'b0);

    // SUB 3-3 with CBZ: zero resolves taken, target pc+16
    x = nop(); x.instr = mk_instr(OP_SUB, 6'd0, 5'd1); x.alu_op = 2'd2;
    x.rs1 = 64'd3; x.rs2 = 64'd3; x.bz = 1'b1; x.pc = 64'h100; x.imm = 64'd4;
    run_op(x, lat);
    check64("sub_result", out_result, 64'd0);
    check1("sub_pc_src", out_pc_src, 1'b1);
    check64("sub_baddr", out_branch_addr, 64'h110);
    tick();

    // Back-to-back with downstream stall
    xa = nop(); xa.instr = mk_instr(OP_ADD, 6'd0, 5'd1); xa.alu_op = 2'd2;
    xa.rs1 = 64'd1; xa.rs2 = 64'd2; xa.rw = 1'b1;
    xb = xa; xb.instr = mk_instr(OP_ADD, 6'd0, 5'd2); xb.rs1 = 64'd10; xb.rs2 = 64'd20;
    ea = model(xa); eb = model(xb);
    out_ready = 1'b0;
    apply(xa); in_valid = 1'b1;
    tick();
    apply(xb);
    for (int i = 0; i < 3; i++) begin
      #1;
      check1("stall_in_ready", in_ready, 1'b0);
      check_out("stall_hold_a", ea);
      tick();
    end
    check_out("stall_still_a", ea);
    out_ready = 1'b1;
    #1;
    check1("stall_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_out("stall_b", eb);
    tick();
    check1("stall_drained", out_valid, 1'b0);

    // LSR by 63
    x = nop(); x.instr = mk_instr(OP_LSR, 6'd63, 5'd4); x.alu_op = 2'd2;
    x.rs1 = 64'h8000_0000_0000_0000; x.rw = 1'b1;
    run_op(x, lat);
    check64("lsr63_result", out_result, 64'd1);
    tick();

    // LSL, ORR with zext immediate, PASS_B with CBNZ
    x = nop(); x.instr = mk_instr(OP_LSL, 6'd4, 5'd5); x.alu_op = 2'd2; x.rs1 = 64'hF;
    run_op(x, lat);
    check64("lsl_result", out_result, 64'hF0);
    tick();
    x = nop(); x.instr = mk_instr(OP_ORR, 6'd0, 5'd6) | 32'h0000_0C00; x.alu_op = 2'd2;
    x.alu_src = 2'd2; x.rs1 = 64'h1;
    run_op(x, lat);
    check_out("orr_zext", model(x));
    tick();
    x = nop(); x.alu_op = 2'd1; x.rs2 = 64'd9; x.bnz = 1'b1;
    run_op(x, lat);
    check64("passb_result", out_result, 64'd9);
    check1("passb_cbnz", out_pc_src, 1'b1);
    tick();

    // Illegal alu_op, illegal alu_src, unknown opcode
    x = nop(); x.alu_op = 2'd3; x.rs1 = 64'd4; x.rs2 = 64'd4; x.rw = 1'b1; x.mw = 1'b1;
    run_op(x, lat);
    check64("ill_op_result", out_result, 64'd0);
    check1("ill_op_flag", out_illegal, 1'b1);
    check1("ill_op_rw", out_reg_write, 1'b0);
    check1("ill_op_mw", out_mem_write, 1'b0);
    tick();
    x = nop(); x.alu_op = 2'd0; x.alu_src = 2'd3; x.rs1 = 64'd4; x.rw = 1'b1;
    run_op(x, lat);
    check_out("ill_src", model(x));
    tick();
    x = nop(); x.alu_op = 2'd2; x.instr = mk_instr(11'h7FF, 6'd0, 5'd7); x.rw = 1'b1;
    run_op(x, lat);
    check_out("ill_opc", model(x));
    tick();

    // MUL 0xFFFF_FFFF * 3
    x = nop(); x.instr = mk_instr(OP_MUL, 6'd0, 5'd8); x.alu_op = 2'd2;
    x.rs1 = 64'hFFFF_FFFF; x.rs2 = 64'd3; x.rw = 1'b1;
    run_op(x, lat);
`ifdef EX_STAGE_MUL_EN
    check64("mul_latency", 64'(lat), 64'd65);
    check64("mul_result", out_result, 64'h2_FFFF_FFFD);
    check_out("mul", model(x));
    tick();
    // Flush ten cycles into a MUL
    apply(x); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check1("mul_busy_ready", in_ready, 1'b0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check1("mul_flush_ready", in_ready, 1'b1);
    check1("mul_flush_valid", out_valid, 1'b0);
    seen = 1'b0;
    repeat (70) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check1("mul_flush_no_out", seen, 1'b0);
`else
    check64("mul_latency", 64'(lat), 64'd1);
    check1("mul_illegal", out_illegal, 1'b1);
    check64("mul_result", out_result, 64'd0);
    tick();
`endif

    // Flush drops the held bundle and the bundle presented that cycle
    out_ready = 1'b0;
    apply(xa); in_valid = 1'b1;
    tick();
    apply(xb); flush = 1'b1;
    #1;
    check1("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check1("flush_valid", out_valid, 1'b0);
    check1("flush_ready_after", in_ready, 1'b1);
    tick();
    check1("flush_dropped", out_valid, 1'b0);

    // Reset wins over flush and an offered bundle
    apply(xa); in_valid = 1'b1;
    tick();
    apply(xb); reset = 1'b1; flush = 1'b1;
    tick();
    #1;
    check1("rst_flush_ready", in_ready, 1'b0);
    check1("rst_flush_valid", out_valid, 1'b0);
    check64("rst_flush_result", out_result, 64'd0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Randomized traffic against a one-deep slot model
    mdl_valid = 1'b0;
    mdl = '0;
    for (int i = 0; i < 400; i++) begin
      x = rnd_bundle();
      apply(x);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !mdl_valid || out_ready;
      check1("rnd_in_ready", in_ready, exp_rdy);
      if (in_valid && exp_rdy) begin
        mdl = model(x);
        mdl_valid = 1'b1;
      end else if (mdl_valid && out_ready) begin
        mdl_valid = 1'b0;
      end
      tick();
      if (mdl_valid) check_out("rnd", mdl);
      else check1("rnd_valid", out_valid, 1'b0);
    end

    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check1("end_idle", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
